// File: rtl/btn_debounce.sv
// Push-button front end: synchroniser, polarity normalisation and counter-based
// debounce FSM producing a clean level, press/release pulses and a 4-bit press count.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  input  logic       cnt_clr,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [3:0] press_count
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic                   w_s;
  logic                   w_press;
  logic                   w_release;
  logic                   w_level_nxt;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;
  logic [3:0]             r_count;

  // Chain resets to the released pin level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{ACTIVE_LOW}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1] ^ ACTIVE_LOW;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press     = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_s) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
          w_press     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!w_s) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_s) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_release   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    w_level_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == RELEASE_WAIT);
  end

  // Outputs are registered from next-state so they change on the transition edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press;
      r_release <= w_release;
      if (cnt_clr) begin
        r_count <= '0;
      end else if (w_press) begin
        r_count <= r_count + 4'd1;
      end
    end
  end

  assign btn_level     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign press_count   = r_count;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: table vectors, directed corner sequences and random
// pin activity checked against a run-length reference model.
module tb_btn_debounce;

  localparam int unsigned D  = 4;
  localparam int unsigned S  = 2;
  localparam bit          AL = 1'b1;

  logic       clk;
  logic       rst;
  logic       btn_in;
  logic       cnt_clr;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic [3:0] press_count;

  btn_debounce #(
    .DEBOUNCE_CYCLES(D),
    .SYNC_STAGES    (S),
    .ACTIVE_LOW     (AL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .cnt_clr      (cnt_clr),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .press_count  (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the level flips on the (D+1)-th consecutive edge that
  // sees a pressed-sample (delayed S edges) differing from the current level.
  bit       m_hist [S];
  bit       m_level;
  int       m_run;
  int       m_cnt;
  bit       m_pp;
  bit       m_rp;

  int n_pp, n_rp, n_ovl;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic model_edge(input bit r, input bit b, input bit c);
    bit pressed_now;
    bit s;
    pressed_now = AL ? !b : b;
    if (r) begin
      for (int i = 0; i < S; i++) m_hist[i] = 1'b0;
      m_level = 1'b0; m_run = 0; m_cnt = 0; m_pp = 1'b0; m_rp = 1'b0;
    end else begin
      s = m_hist[S-1];
      for (int i = S - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = pressed_now;
      m_pp = 1'b0; m_rp = 1'b0;
      if (s != m_level) begin
        m_run++;
        if (m_run == D + 1) begin
          m_level = s;
          m_run   = 0;
          if (s) m_pp = 1'b1; else m_rp = 1'b1;
        end
      end else begin
        m_run = 0;
      end
      if (c) m_cnt = 0;
      else if (m_pp) m_cnt = (m_cnt + 1) % 16;
    end
  endtask

  task automatic step(input bit r, input bit b, input bit c);
    rst = r; btn_in = b; cnt_clr = c;
    @(posedge clk);
    model_edge(r, b, c);
    #1;
    chk("m_level", 32'(btn_level), 32'(m_level));
    chk("m_press_pulse", 32'(press_pulse), 32'(m_pp));
    chk("m_release_pulse", 32'(release_pulse), 32'(m_rp));
    chk("m_press_count", 32'(press_count), 32'(m_cnt));
    if (press_pulse === 1'b1) n_pp++;
    if (release_pulse === 1'b1) n_rp++;
    if (press_pulse === 1'b1 && release_pulse === 1'b1) n_ovl++;
  endtask

  task automatic hold(input bit b, input int n, input bit c);
    for (int i = 0; i < n; i++) step(1'b0, b, c);
  endtask

  typedef struct {
    bit       r;
    bit       b;
    bit       c;
    bit       lvl;
    bit       pp;
    bit       rp;
    bit [3:0] cnt;
  } vec_t;

  vec_t tbl [21];

  initial begin
    int first_pp;
    int pulses;
    bit pins [12];
    bit b;
    int len;

    // Reset while pressed, clean press, clean release, then clear.
    for (int i = 0;  i < 3;  i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    for (int i = 3;  i < 9;  i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1};
    for (int i = 10; i < 12; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
    for (int i = 12; i < 18; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};
    tbl[20] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].r, tbl[i].b, tbl[i].c);
      chk($sformatf("tbl%0d_level", i), 32'(btn_level), 32'(tbl[i].lvl));
      chk($sformatf("tbl%0d_press", i), 32'(press_pulse), 32'(tbl[i].pp));
      chk($sformatf("tbl%0d_release", i), 32'(release_pulse), 32'(tbl[i].rp));
      chk($sformatf("tbl%0d_count", i), 32'(press_count), 32'(tbl[i].cnt));
    end

    // Bounce: the single released sample restarts qualification.
    hold(1'b1, 8, 1'b0);
    pins = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    first_pp = -1; pulses = 0;
    for (int j = 0; j < 12; j++) begin
      step(1'b0, pins[j], 1'b0);
      if (press_pulse === 1'b1) begin
        pulses++;
        if (first_pp < 0) first_pp = j;
      end
    end
    chk("bounce_pulse_edge", 32'(first_pp), 32'd9);
    chk("bounce_pulse_count", 32'(pulses), 32'd1);
    chk("bounce_press_count", 32'(press_count), 32'd1);
    hold(1'b1, 10, 1'b0);

    // Clear colliding with a press.
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      hold(1'b0, 10, 1'b0);
      hold(1'b1, 10, 1'b0);
    end
    chk("collide_pre_count", 32'(press_count), 32'd5);
    hold(1'b0, 6, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("collide_pulse", 32'(press_pulse), 32'd1);
    chk("collide_count", 32'(press_count), 32'd0);
    hold(1'b0, 4, 1'b0);
    hold(1'b1, 10, 1'b0);
    hold(1'b0, 10, 1'b0);
    chk("collide_next_count", 32'(press_count), 32'd1);
    hold(1'b1, 10, 1'b0);

    // Sixteen press/release cycles with wrap.
    step(1'b0, 1'b1, 1'b1);
    n_pp = 0; n_rp = 0; n_ovl = 0;
    for (int i = 0; i < 16; i++) begin
      hold(1'b0, 10, 1'b0);
      chk($sformatf("wrap_count_%0d", i + 1), 32'(press_count), 32'((i + 1) % 16));
      hold(1'b1, 10, 1'b0);
    end
    chk("wrap_press_pulses", 32'(n_pp), 32'd16);
    chk("wrap_release_pulses", 32'(n_rp), 32'd16);
    chk("wrap_overlap", 32'(n_ovl), 32'd0);

    // Reset two edges after entering PRESS_WAIT, button kept held.
    hold(1'b0, 4, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("rstmid_level", 32'(btn_level), 32'd0);
    chk("rstmid_count", 32'(press_count), 32'd0);
    first_pp = -1; pulses = 0;
    for (int j = 0; j < 20; j++) begin
      step(1'b0, 1'b0, 1'b0);
      if (press_pulse === 1'b1) begin
        pulses++;
        if (first_pp < 0) first_pp = j;
      end
    end
    chk("rstmid_pulse_edge", 32'(first_pp), 32'd6);
    chk("rstmid_pulse_count", 32'(pulses), 32'd1);
    chk("rstmid_final_count", 32'(press_count), 32'd1);

    // Random pin activity with occasional clears and resets.
    n_ovl = 0;
    for (int k = 0; k < 600; k++) begin
      b   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++)
        step(1'($urandom_range(0, 300) == 0), b, 1'($urandom_range(0, 40) == 0));
    end
    chk("random_overlap", 32'(n_ovl), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Input-side companion to the LED counter: turns a raw, bouncy, asynchronous push-button into clean synchronous events.
- Synchronises the button, normalises its polarity, and debounces it with a counter-based FSM.
- Emits a debounced level, one-cycle press/release pulses, and a 4-bit wrap-around press count for direct display on the 4 LEDs.

Parameters:
- DEBOUNCE_CYCLES, 250000, stable-sample count required to accept a level change; legal range is 2 or more.
- SYNC_STAGES, 2, number of synchroniser flops on btn_in; legal range is 2 or more.
- ACTIVE_LOW, 1, set to 1 when the board button reads 0 while pressed; set to 0 when it reads 1 while pressed.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_in  input  1  raw asynchronous button pin.
- cnt_clr  input  1  synchronous clear of press_count.
- btn_level  output  1  debounced state; 1 means pressed.
- press_pulse  output  1  high for exactly one cycle per accepted press.
- release_pulse  output  1  high for exactly one cycle per accepted release.
- press_count  output  4  number of accepted presses, modulo 16.

Behaviour:
- Reset, applied when rst is high at a clk edge:
  - Synchroniser flops load the released pin level (1 if ACTIVE_LOW, else 0).
  - State goes to IDLE; debounce counter goes to 0.
  - btn_level, press_pulse, release_pulse and press_count all go to 0.
  - rst overrides every other input, including a debounce in progress, which is aborted with no pulse.
- Synchroniser: a SYNC_STAGES-deep flop chain on btn_in. Its last stage, XORed with ACTIVE_LOW, gives the sample s (1 = pressed). No logic uses btn_in directly.
- Debounce counter: width is clog2(DEBOUNCE_CYCLES). It is cleared on every state entry.
- FSM states and transitions:
  - IDLE (released, stable): if s=1, go to PRESS_WAIT with cnt=0.
  - PRESS_WAIT:
    - if s=0, go to IDLE with no output change (bounce rejected);
    - else if cnt=DEBOUNCE_CYCLES-1, go to PRESSED;
    - else cnt increments.
  - PRESSED (pressed, stable): if s=0, go to RELEASE_WAIT with cnt=0.
  - RELEASE_WAIT:
    - if s=1, go back to PRESSED (bounce rejected);
    - else if cnt=DEBOUNCE_CYCLES-1, go to IDLE;
    - else cnt increments.
- Outputs are all registered and are never driven combinationally from the state:
  - btn_level is 1 in PRESSED and RELEASE_WAIT, and 0 in IDLE and PRESS_WAIT.
  - press_pulse is asserted on the same edge that btn_level rises, and only that one.
  - release_pulse is asserted on the same edge that btn_level falls, and only that one.
  - press_pulse and release_pulse are never high together.
- Latency: when the pin changes and stays stable, btn_level changes exactly SYNC_STAGES+DEBOUNCE_CYCLES edges after the first edge that samples the new pin level.
- Bounce rejection: any single-cycle opposite sample during a WAIT state restarts qualification from the stable state. The next attempt needs a full DEBOUNCE_CYCLES run again.
- press_count:
  - increments by 1 on the edge that asserts press_pulse;
  - wraps from 15 to 0 with no flag;
  - is cleared to 0 by cnt_clr, which has priority over increment; if cnt_clr and a press occur on the same edge, the result is 0 and that press is not counted;
  - is unaffected by release events.
- A button held indefinitely produces exactly one press_pulse, with no auto-repeat.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, SYNC_STAGES=2, ACTIVE_LOW=1.
1. Reset: hold rst for 3 edges with btn_in=0 (pressed) -> btn_level=0, press_pulse=0, press_count=0 throughout; after release of rst, btn_level rises 6 edges later.
2. Clean press: btn_in 1->0 sampled at edge k and held -> btn_level=1 and press_pulse=1 at edge k+6; press_pulse=0 at k+7; press_count=1.
3. Bounce: btn_in pattern 0,0,1,0,0,0,0,0,0 (one sample per edge) -> no pulse within 6 edges of the first 0; press_pulse occurs 6 edges after the last 1->0 transition; press_count=1.
4. Release and wrap: perform 16 clean press/release cycles -> 16 press_pulse and 16 release_pulse events, never overlapping; press_count reads 15 after the 15th press and 0 after the 16th.
5. Clear collision: cnt_clr=1 on the edge that press_pulse asserts, with press_count=5 -> press_count=0 after that edge; the next press gives 1.
6. Reset mid-debounce: assert rst 2 edges after a press enters PRESS_WAIT -> state returns to IDLE, no press_pulse, press_count=0; with the button still held, a press is accepted 6 edges after rst deasserts.
